// File: rtl/boot_loader_if.sv
// boot_loader_if: SDRAM write-request bus between the boot loader and the
// SDRAM controller.
//   mem_we   - write request, held until acknowledged
//   mem_addr - SDRAM byte address, ADDR_W bits
//   mem_bank - SDRAM bank select, BANK_W bits
//   mem_din  - write data byte
//   mem_ack  - one-cycle pulse from the controller: current write accepted
// Modports: master (boot loader side), slave (controller side).
interface boot_loader_if #(
    parameter int ADDR_W = 23,
    parameter int BANK_W = 1
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BANK_W-1:0] mem_bank;
    logic [7:0]        mem_din;
    logic              mem_ack;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_bank,
        output mem_din,
        input  mem_ack
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_bank,
        input  mem_din,
        output mem_ack
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: download-to-SDRAM engine for the ROM boot path.
// Accepts the ioctl byte stream for index 0, maps each 2^SLOT_W byte chunk
// through a runtime slot table to an SDRAM page and bank, buffers the bytes
// in a small FIFO and writes them out over a we/ack handshake.
// Optional macro BOOT_LOADER_FILL_EN: pad the trailing partial slot with 0xFF.
// Ports:
//   clk_sys, reset          - clock, asynchronous active-high reset
//   ioctl_download/index/wr/addr/dout - mist_io download stream
//   slot_page, slot_bank    - packed per-slot page and bank table
//   mem                     - SDRAM write bus (boot_loader_if.master)
//   busy                    - high from download start until done
//   done                    - one-cycle pulse when loading has finished
//   slot_loaded             - bit i set once a byte was written to slot i
//   overflow                - sticky: a byte was dropped on a full FIFO
module boot_loader #(
    parameter int ADDR_W     = 23,
    parameter int SLOT_W     = 14,
    parameter int NUM_SLOTS  = 8,
    parameter int BANK_W     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk_sys,
    input  logic                                  reset,
    input  logic                                  ioctl_download,
    input  logic [7:0]                            ioctl_index,
    input  logic                                  ioctl_wr,
    input  logic [24:0]                           ioctl_addr,
    input  logic [7:0]                            ioctl_dout,
    input  logic [NUM_SLOTS*(ADDR_W-SLOT_W)-1:0]  slot_page,
    input  logic [NUM_SLOTS*BANK_W-1:0]           slot_bank,
    boot_loader_if.master                         mem,
    output logic                                  busy,
    output logic                                  done,
    output logic [NUM_SLOTS-1:0]                  slot_loaded,
    output logic                                  overflow
);
    localparam int PAGE_W  = ADDR_W - SLOT_W;
    localparam int SIDX_W  = 25 - SLOT_W;
    localparam int ENTRY_W = ADDR_W + BANK_W + 8;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
`ifdef BOOT_LOADER_FILL_EN
        FILL,
`endif
        FIN
    } state_t;

    state_t state;
    logic   dl_prev;

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [BANK_W-1:0] req_bank;
    logic [7:0]        req_din;

    assign mem.mem_we   = req_we;
    assign mem.mem_addr = req_addr;
    assign mem.mem_bank = req_bank;
    assign mem.mem_din  = req_din;

    // Slot decode of the incoming byte.
    logic [SIDX_W-1:0]    wr_slot;
    logic [NUM_SLOTS-1:0] wr_hit;
    logic [PAGE_W-1:0]    wr_page;
    logic [BANK_W-1:0]    wr_bank;
    logic                 wr_in_range;

    assign wr_slot = ioctl_addr[24:SLOT_W];

    always_comb begin
        wr_hit  = '0;
        wr_page = '0;
        wr_bank = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (wr_slot == SIDX_W'(i)) begin
                wr_hit[i] = 1'b1;
                wr_page   = slot_page[i*PAGE_W +: PAGE_W];
                wr_bank   = slot_bank[i*BANK_W +: BANK_W];
            end
        end
    end

    assign wr_in_range = |wr_hit;

    // Write buffer. The head entry stays in the FIFO until its write is
    // acknowledged, so the in-flight request counts against capacity.
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W:0]     fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               accept_wr;
    logic               push;
    logic               pop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign accept_wr  = (state == LOAD) && ioctl_wr && wr_in_range;
    assign push       = accept_wr && !fifo_full;
    assign pop        = req_we && mem.mem_ack && !fifo_empty;

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wr_page, ioctl_addr[SLOT_W-1:0], wr_bank, ioctl_dout};
        end
    end

`ifdef BOOT_LOADER_FILL_EN
    // End-of-data tracking and slot lookup for the last byte written.
    logic [24:0]          last_a;
    logic [SIDX_W-1:0]    last_slot;
    logic [NUM_SLOTS-1:0] last_hit;
    logic [PAGE_W-1:0]    last_page;
    logic [BANK_W-1:0]    last_bank;
    logic                 fill_start;
    logic [SLOT_W-1:0]    fill_off;
    logic [PAGE_W-1:0]    fill_page;
    logic [BANK_W-1:0]    fill_bank;

    assign last_slot = SIDX_W'((last_a - 25'd1) >> SLOT_W);

    always_comb begin
        last_hit  = '0;
        last_page = '0;
        last_bank = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (last_slot == SIDX_W'(i)) begin
                last_hit[i] = 1'b1;
                last_page   = slot_page[i*PAGE_W +: PAGE_W];
                last_bank   = slot_bank[i*BANK_W +: BANK_W];
            end
        end
    end

    assign fill_start = (last_a[SLOT_W-1:0] != '0) && (|last_hit);
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dl_prev     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_bank    <= '0;
            req_din     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            slot_loaded <= '0;
            overflow    <= 1'b0;
`ifdef BOOT_LOADER_FILL_EN
            last_a      <= '0;
            fill_off    <= '0;
            fill_page   <= '0;
            fill_bank   <= '0;
`endif
        end else begin
            dl_prev <= ioctl_download;
            done    <= 1'b0;

            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                slot_loaded <= slot_loaded | wr_hit;
`ifdef BOOT_LOADER_FILL_EN
                last_a      <= ioctl_addr + 25'd1;
`endif
            end
            if (accept_wr && fifo_full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase

            // Request stage: a request drops the cycle after its ack; the next
            // one is issued from the FIFO head while no request is outstanding.
            if (req_we) begin
                if (mem.mem_ack) begin
                    req_we <= 1'b0;
                end
            end else if (!fifo_empty) begin
                req_we                        <= 1'b1;
                {req_addr, req_bank, req_din} <= fifo_mem[rd_ptr];
            end

            case (state)
                IDLE: begin
                    if (ioctl_download && !dl_prev && (ioctl_index == 8'd0)) begin
                        state       <= LOAD;
                        slot_loaded <= '0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
`ifdef BOOT_LOADER_FILL_EN
                        last_a      <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (!ioctl_download && dl_prev) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !req_we) begin
`ifdef BOOT_LOADER_FILL_EN
                        if (fill_start) begin
                            state     <= FILL;
                            fill_off  <= last_a[SLOT_W-1:0];
                            fill_page <= last_page;
                            fill_bank <= last_bank;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
`else
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`endif
                    end
                end
`ifdef BOOT_LOADER_FILL_EN
                FILL: begin
                    // FIFO is empty here, so this overrides nothing from above.
                    if (!req_we) begin
                        req_we   <= 1'b1;
                        req_addr <= {fill_page, fill_off};
                        req_bank <= fill_bank;
                        req_din  <= 8'hFF;
                    end else if (mem.mem_ack) begin
                        if (fill_off == '1) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            fill_off <= fill_off + 1'b1;
                        end
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: scoreboard bench for boot_loader. Expected SDRAM writes are
// queued as stimulus is issued; a monitor pops and compares on each accepted
// write (mem_we && mem_ack). An ack responder models the SDRAM controller.
module tb_boot_loader;
`ifdef BOOT_LOADER_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  dout;
    logic [71:0] slot_page;
    logic [7:0]  slot_bank;
    logic        busy;
    logic        done;
    logic [7:0]  slot_loaded;
    logic        overflow;

    logic resp_ack  = 1'b0;
    logic force_ack = 1'b0;

    always #5 clk = ~clk;

    boot_loader_if #(.ADDR_W(23), .BANK_W(1)) bus ();
    assign bus.mem_ack = resp_ack | force_ack;

    boot_loader #(
        .ADDR_W(23), .SLOT_W(14), .NUM_SLOTS(8), .BANK_W(1), .FIFO_DEPTH(4)
    ) dut (
        .clk_sys(clk), .reset(rst),
        .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(dout),
        .slot_page(slot_page), .slot_bank(slot_bank),
        .mem(bus),
        .busy(busy), .done(done), .slot_loaded(slot_loaded), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int done_cnt = 0;
    int wr_cnt = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int last_done_cyc = 0;
    int ack_delay = 2;
    bit ack_hold = 1'b0;
    int wcnt = 0;
    logic prev_we = 1'b0;
    logic [31:0] cap = '0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endfunction

    task automatic pad(input logic [8:0] page, input logic bank, input int from);
        for (int off = from; off < 16384; off++) exp_q.push_back({page, 14'(off), bank, 8'hFF});
    endtask

    // SDRAM controller model: ack after ack_delay cycles of mem_we.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
            end else if (bus.mem_we && !ack_hold) begin
                wcnt++;
                if (wcnt >= ack_delay) begin
                    resp_ack = 1'b1;
                    wcnt = 0;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [31:0] cur;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            cur = {bus.mem_addr, bus.mem_bank, bus.mem_din};
            if (bus.mem_we && !prev_we) cap = cur;
            if (bus.mem_we && bus.mem_ack) begin
                wr_cnt++;
                last_acc_cyc = cyc;
                check("hold_stable", cur, cap);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got %h, required no write", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("write", cur, e);
                end
            end
            prev_we = bus.mem_we;
        end
    end

    task automatic start_dl(input logic [7:0] i);
        @(posedge clk); #1;
        idx = i;
        dl  = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic end_dl();
        @(posedge clk); #1;
        dl = 1'b0;
    endtask

    task automatic send_seq(input logic [24:0] a0, input int n, input logic [7:0] d0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr = 1'b1;
            ioctl_addr = a0 + 25'(i);
            dout = d0 + 8'(i);
        end
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > base) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(got), 1);
    endtask

    task automatic wait_q(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("queue_drain", exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run still active at time limit, required completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bw;
        int bd;
        int seen;
        rst = 1'b0; dl = 1'b0; idx = '0; wr = 1'b0; ioctl_addr = '0; dout = '0;
        slot_page = {9'h055, 9'h055, 9'h055, 9'h055, 9'h1ff, 9'h107, 9'h100, 9'h000};
        slot_bank = 8'b0000_1010;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_bank", bus.mem_bank, 0);
        check("rst_mem_din", bus.mem_din, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_slot_loaded", slot_loaded, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Basic mapping across four slots.
        ack_delay = 2; bw = wr_cnt; bd = done_cnt;
        exp_q.push_back({23'h000000, 1'b0, 8'h11});
        exp_q.push_back({23'h400000, 1'b1, 8'h22});
        exp_q.push_back({23'h41C000, 1'b0, 8'h33});
        exp_q.push_back({23'h7FC000, 1'b1, 8'h44});
        start_dl(8'd0);
        check("busy_load", busy, 1);
        send_seq(25'h0000, 1, 8'h11);
        send_seq(25'h4000, 1, 8'h22);
        send_seq(25'h8000, 1, 8'h33);
        send_seq(25'hC000, 1, 8'h44);
        wait_q(200);
        if (FILL_ON) begin
            pad(9'h1ff, 1'b1, 1);
            ack_delay = 1;
        end
        end_dl();
        wait_done(40000, bd);
        repeat (3) @(negedge clk);
        check("basic_writes", wr_cnt - bw, 4 + (FILL_ON ? 16383 : 0));
        check("basic_done_once", done_cnt - bd, 1);
        check("basic_slot_loaded", slot_loaded, 8'h0F);
        check("basic_busy_end", busy, 0);
        check("basic_overflow", overflow, 0);
        check("basic_queue", exp_q.size(), 0);

        // Non-zero index is ignored.
        bd = done_cnt;
        start_dl(8'd1);
        repeat (3) @(negedge clk);
        check("idx1_busy", busy, 0);
        end_dl();
        repeat (3) @(negedge clk);
        check("idx1_slot_loaded_kept", slot_loaded, 8'h0F);
        check("idx1_no_done", done_cnt - bd, 0);

        // Out-of-range slot is discarded silently.
        ack_delay = 2; bw = wr_cnt; bd = done_cnt;
        start_dl(8'd0);
        send_seq(25'h20000, 1, 8'h99);
        end_dl();
        wait_done(200, bd);
        repeat (3) @(negedge clk);
        check("oor_writes", wr_cnt - bw, 0);
        check("oor_slot_loaded", slot_loaded, 0);
        check("oor_overflow", overflow, 0);
        check("oor_done_once", done_cnt - bd, 1);

        // Backpressure: ack held low, six strobes into a 4-deep buffer.
        ack_hold = 1'b1; ack_delay = 1; bw = wr_cnt; bd = done_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back({23'h003FFA + 23'(i), 1'b0, 8'hA0 + 8'(i)});
        start_dl(8'd0);
        send_seq(25'h3FFA, 6, 8'hA0);
        @(negedge clk);
        check("bp_overflow", overflow, 1);
        repeat (4) @(negedge clk);
        check("bp_we_held", bus.mem_we, 1);
        check("bp_addr_held", bus.mem_addr, 23'h003FFA);
        check("bp_din_held", bus.mem_din, 8'hA0);
        check("bp_no_write_yet", wr_cnt - bw, 0);
        if (FILL_ON) pad(9'h000, 1'b0, 16'h3FFE);
        ack_hold = 1'b0;
        end_dl();
        wait_done(400, bd);
        repeat (3) @(negedge clk);
        check("bp_writes", wr_cnt - bw, 4 + (FILL_ON ? 2 : 0));
        check("bp_slot_loaded", slot_loaded, 8'h01);
        check("bp_overflow_sticky", overflow, 1);
        check("bp_queue", exp_q.size(), 0);

        // Short final chunk in slot 1: padded only when fill is built in.
        ack_delay = 1; bw = wr_cnt; bd = done_cnt;
        exp_q.push_back({23'h400000, 1'b1, 8'h5A});
        exp_q.push_back({23'h400001, 1'b1, 8'h5B});
        if (FILL_ON) pad(9'h100, 1'b1, 2);
        start_dl(8'd0);
        send_seq(25'h4000, 2, 8'h5A);
        end_dl();
        wait_done(40000, bd);
        check("fill_done_after_last_write",
              64'((last_done_cyc - last_acc_cyc >= 1) && (last_done_cyc - last_acc_cyc <= 3)), 1);
        repeat (3) @(negedge clk);
        check("fill_writes", wr_cnt - bw, 2 + (FILL_ON ? 16382 : 0));
        check("fill_queue", exp_q.size(), 0);
        check("fill_slot_loaded", slot_loaded, 8'h02);
        check("fill_overflow_cleared", overflow, 0);

        // Reset while a write is outstanding.
        ack_hold = 1'b1; bw = wr_cnt;
        start_dl(8'd0);
        send_seq(25'h0000, 1, 8'h77);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                seen = 1;
                break;
            end
        end
        check("rst_mid_we_seen", seen, 1);
        rst = 1'b1;
        dl = 1'b0;
        #1;
        check("rst_mid_we", bus.mem_we, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_slot_loaded", slot_loaded, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1 force_ack = 1'b1;
        @(posedge clk); #1 force_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.mem_we) seen = 1;
        end
        check("rst_mid_no_we_after", seen, 0);
        check("rst_mid_busy_after", busy, 0);
        check("rst_mid_writes", wr_cnt - bw, 0);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Parametrised download-to-SDRAM engine for the ROM boot path.
- Takes the mist_io ioctl byte stream for index 0, maps each 16 KB chunk through a runtime slot table to an SDRAM page and bank, and buffers writes in a FIFO.
- Issues writes to the sdram controller with a we/ack handshake.
- Replaces the fixed combinational chunk decode.
- Adds per-slot load flags, overflow detection and optional 0xFF padding of a short final chunk.

Parameters:
- ADDR_W, 23, SDRAM byte address width.
- SLOT_W, 14, log2 of slot size in bytes.
- NUM_SLOTS, 8, number of mappable slots (valid range 1..64).
- BANK_W, 1, SDRAM bank-select width.
- FIFO_DEPTH, 4, write buffer entries (power of 2, at least 2).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  download target; only 0 is accepted.
- ioctl_wr  in  1  byte strobe, one cycle per byte.
- ioctl_addr  in  25  byte offset within the file.
- ioctl_dout  in  8  byte data.
- slot_page  in  NUM_SLOTS*(ADDR_W-SLOT_W)  page per slot; slot i occupies bits [i*(ADDR_W-SLOT_W) +: ADDR_W-SLOT_W].
- slot_bank  in  NUM_SLOTS*BANK_W  bank per slot, packed the same way.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  write address.
- mem_bank  out  BANK_W  write bank.
- mem_din  out  8  write data.
- mem_ack  in  1  one-cycle pulse: the current write was accepted.
- busy  out  1  high from download start until done.
- done  out  1  one-cycle pulse when loading has finished.
- slot_loaded  out  NUM_SLOTS  bit i set once any byte has been written to slot i.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous) values:
  - FSM goes to IDLE and the FIFO is emptied.
  - mem_we=0, mem_addr=0, mem_bank=0, mem_din=0.
  - busy=0, done=0, slot_loaded=0, overflow=0.
- Reset asserted mid-write drops the in-flight request with no further mem_we. A later mem_ack is ignored.
- FSM states: IDLE, LOAD, DRAIN, FILL, FIN.
- IDLE:
  - Rising edge of ioctl_download with ioctl_index==0 moves to LOAD.
  - On that transition: clear slot_loaded and overflow, set busy=1, and clear the end-of-data register last_a.
  - Any other index is ignored and the state stays IDLE.
- Slot decode, applied on each ioctl_wr while in LOAD:
  - s = ioctl_addr[24:SLOT_W].
  - If s >= NUM_SLOTS, the byte is discarded silently (not counted as overflow).
  - Otherwise the FIFO receives {page[s], ioctl_addr[SLOT_W-1:0], bank[s], data}, slot_loaded[s] is set, and last_a is set to ioctl_addr+1.
  - If the FIFO is full when ioctl_wr arrives, the byte is dropped and overflow is set.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Output side:
  - When the FIFO is non-empty and no request is outstanding, the head is loaded into mem_addr/mem_bank/mem_din with mem_we=1 on the next cycle.
  - mem_we and all data stay stable until the mem_ack cycle.
  - mem_we drops in the cycle after mem_ack. The next request may then be issued, so back-to-back throughput is one write per ack plus one cycle.
  - mem_ack with mem_we=0 is ignored.
- LOAD -> DRAIN on the falling edge of ioctl_download.
- DRAIN -> FILL (or FIN when the fill feature is compiled out) once the FIFO is empty and no request is outstanding.
- FILL:
  - If last_a[SLOT_W-1:0] != 0 and the slot of last_a-1 is in range, write 0xFF to every remaining offset from last_a[SLOT_W-1:0] up to 2^SLOT_W-1 of that slot, through the same we/ack handshake.
  - Otherwise go straight to FIN.
- FIN: done=1 for one cycle, busy=0, next state IDLE.
- A new download rising edge before IDLE is reached is ignored until IDLE.
- Address arithmetic: mem_addr = {page, offset}, total width ADDR_W. The offset counter in FILL wraps only at the slot end and never carries into the page.

Optional Feature:
- Macro: BOOT_LOADER_FILL_EN.
- Defined: the FILL state exists and pads the trailing partial slot with 0xFF as described above.
- Undefined: DRAIN goes directly to FIN; no padding writes are issued and no FILL logic is synthesised.

Test Plan:
- Basic mapping:
  - Stimulus: NUM_SLOTS=8; slot_page = {0x1ff,0x107,0x100,0x000,...}; bytes at 0x0000, 0x4000, 0x8000, 0xC000 with mem_ack 2 cycles after mem_we.
  - Response: writes at 0x000000, 0x400000, 0x41C000, 0x7FC000 in order; slot_loaded = 0b00001111; done pulses once.
- Out-of-range:
  - Stimulus: byte at ioctl_addr 0x20000.
  - Response: no mem_we; slot_loaded unchanged; overflow=0.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4; hold mem_ack low; send 6 consecutive ioctl_wr.
  - Response: overflow=1; exactly 4 writes appear once ack resumes; mem_we and data stable while ack is low.
- Fill (macro defined):
  - Stimulus: load 0x4002 bytes with slot 1 mapped to page 0x100.
  - Response: after the drain, 0x3FFE writes of 0xFF at 0x400002..0x403FFF, then done.
- Fill compiled out:
  - Stimulus: same load as the fill case.
  - Response: done appears right after the 0x4002nd write; no 0xFF writes.
- Reset mid-operation:
  - Stimulus: assert reset while mem_we=1.
  - Response: mem_we=0, busy=0 and slot_loaded=0 immediately (asynchronous); a following mem_ack produces no activity.
